cic_sample_fifo: RTL and testbench

CIC_SAMPLE_FIFO -- requirements
Module: cic_sample_fifo

---
 rtl/cic_sample_fifo.sv | 152 +++++++++++++++
 tb/tb_cic_sample_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cic_sample_fifo.sv
// cic_sample_fifo: decimation timing for a CIC filter plus a small show-ahead
// sample FIFO. A free-running counter produces the decimated clock and one
// capture strobe per period; after a settle phase the sampled CIC output is
// pushed into the FIFO, which the consumer drains with a valid/ready handshake.
module cic_sample_fifo #(
  parameter int DECIMATION_FACTOR = 256,
  parameter int CLOCK_WIDTH       = $clog2(DECIMATION_FACTOR),
  parameter int NUMBITS           = 3*CLOCK_WIDTH+1,
  parameter int CAPTURE_DELAY     = 4,
  parameter int SETTLE_SAMPLES    = 3,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [NUMBITS-1:0]           cic_out,
  output logic                         divided_clk,
  output logic [NUMBITS-1:0]           out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(FIFO_DEPTH):0]  level,
  output logic                         overflow,
  input  logic                         clr_ovf,
  output logic [15:0]                  sample_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [CLOCK_WIDTH-1:0] CNT_LAST    = CLOCK_WIDTH'(DECIMATION_FACTOR - 1);
  localparam logic [CLOCK_WIDTH-1:0] CNT_HALF    = CLOCK_WIDTH'(DECIMATION_FACTOR / 2);
  localparam logic [CLOCK_WIDTH-1:0] CNT_CAPTURE = CLOCK_WIDTH'(CAPTURE_DELAY);
  localparam logic [2:0]             SETTLE_MAX  = 3'(SETTLE_SAMPLES);
  localparam logic [LW-1:0]          LEVEL_FULL  = LW'(FIFO_DEPTH);

  // Decimation timing state
  logic [CLOCK_WIDTH-1:0] div_cnt_reg, div_cnt_next;
  logic                   divided_clk_reg, divided_clk_next;
  logic [2:0]             settle_cnt_reg, settle_cnt_next;

  // FIFO state
  logic [NUMBITS-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]          rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]          level_reg, level_next;
  logic                   overflow_reg, overflow_next;
  logic [15:0]            sample_count_reg, sample_count_next;

  // Per-cycle events
  logic capture;
  logic keep;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Capture decision: one strobe per period, discarded while settling
  always_comb begin
    capture = enable && (div_cnt_reg == CNT_CAPTURE);
    keep    = capture && (settle_cnt_reg >= SETTLE_MAX);
    full    = (level_reg == LEVEL_FULL);
    pop     = (level_reg != '0) && out_ready;
    // A full FIFO still accepts a sample when the head leaves on the same edge
    push    = keep && (!full || pop);
    drop    = keep && full && !pop;
  end

  // Next-state for the counter, decimated clock and settle counter
  always_comb begin
    div_cnt_next     = div_cnt_reg;
    settle_cnt_next  = settle_cnt_reg;
    if (enable) begin
      div_cnt_next = (div_cnt_reg == CNT_LAST) ? '0 : div_cnt_reg + 1'b1;
    end
    // Registered from the next count so the flop always mirrors div_cnt >= D/2
    divided_clk_next = (div_cnt_next >= CNT_HALF);
    if (!enable) begin
      settle_cnt_next = '0;
    end else if (capture && (settle_cnt_reg < SETTLE_MAX)) begin
      settle_cnt_next = settle_cnt_reg + 1'b1;
    end
  end

  // Next-state for pointers, occupancy, overflow flag and push counter
  always_comb begin
    wr_ptr_next       = wr_ptr_reg;
    rd_ptr_next       = rd_ptr_reg;
    level_next        = level_reg;
    overflow_next     = overflow_reg;
    sample_count_next = sample_count_reg;
    if (push) begin
      wr_ptr_next       = wr_ptr_reg + 1'b1;
      sample_count_next = sample_count_reg + 16'd1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({push, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
    // A new drop wins over a coincident clear
    if (drop) begin
      overflow_next = 1'b1;
    end else if (clr_ovf) begin
      overflow_next = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_reg      <= '0;
      divided_clk_reg  <= 1'b0;
      settle_cnt_reg   <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      level_reg        <= '0;
      overflow_reg     <= 1'b0;
      sample_count_reg <= '0;
    end else begin
      div_cnt_reg      <= div_cnt_next;
      divided_clk_reg  <= divided_clk_next;
      settle_cnt_reg   <= settle_cnt_next;
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      level_reg        <= level_next;
      overflow_reg     <= overflow_next;
      sample_count_reg <= sample_count_next;
    end
  end

  // Sample storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= cic_out;
    end
  end

  // Show-ahead head entry, forced to zero while empty
  always_comb begin
    out_valid = (level_reg != '0);
    out_data  = out_valid ? mem[rd_ptr_reg] : '0;
  end

  assign divided_clk  = divided_clk_reg;
  assign level        = level_reg;
  assign overflow     = overflow_reg;
  assign sample_count = sample_count_reg;

endmodule

// File: tb/tb_cic_sample_fifo.sv
// tb_cic_sample_fifo: directed stimulus with a scoreboard queue; a negedge
// monitor pops expected samples whenever the DUT hands one over.
module tb_cic_sample_fifo;

  localparam int NB = 25;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [NB-1:0] cic_out;
  logic          divided_clk;
  logic [NB-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    level;
  logic          overflow;
  logic          clr_ovf;
  logic [15:0]   sample_count;

  int checks   = 0;
  int failures = 0;
  int phase    = 0;  // bench view of the decimation counter before the next edge
  logic [NB-1:0] exp_q[$];

  cic_sample_fifo dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .cic_out      (cic_out),
    .divided_clk  (divided_clk),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .overflow     (overflow),
    .clr_ovf      (clr_ovf),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Advance one clock edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    if (!reset_n) phase = 0;
    else if (enable) phase = (phase + 1) % 256;
    #1;
  endtask

  // Run up to the next capture edge presenting v; optionally expect it kept
  task automatic capture(input logic [NB-1:0] v, input bit keep, input bit clr);
    int guard = 0;
    while (phase != 4 && guard < 300) begin
      step();
      guard++;
    end
    cic_out = v;
    clr_ovf = clr;
    if (keep) exp_q.push_back(v);
    $display("capture value=%0d keep=%0d clr_ovf=%0d", v, keep, clr);
    step();
    clr_ovf = 1'b0;
  endtask

  // Scoreboard monitor: a handshake seen mid-cycle completes on the next edge
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected actual=%0d required=none", out_data);
      end else begin
        logic [NB-1:0] e;
        e = exp_q.pop_front();
        $display("pop data=%0d expected=%0d", out_data, e);
        if (out_data !== e) begin
          failures++;
          $display("FAIL pop_data actual=%0d required=%0d", out_data, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0; cic_out = '0;
    repeat (3) step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_dclk", 32'(divided_clk), 0);
    chk("rst_count", 32'(sample_count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_data", 32'(out_data), 0);

    // First decimation period: divided_clk timing, first capture discarded
    reset_n = 1'b1; enable = 1'b1; out_ready = 1'b1;
    while (phase != 127) step();
    chk("dclk_127", 32'(divided_clk), 0);
    step();
    chk("dclk_128", 32'(divided_clk), 1);
    while (phase != 255) step();
    chk("dclk_255", 32'(divided_clk), 1);
    step();
    chk("dclk_wrap", 32'(divided_clk), 0);
    chk("settle1_level", 32'(level), 0);
    capture(25'd11, 1'b0, 1'b0);
    capture(25'd12, 1'b0, 1'b0);
    chk("settle3_valid", 32'(out_valid), 0);
    capture(25'd100, 1'b1, 1'b0);  // enabled edge 773
    chk("first_valid", 32'(out_valid), 1);
    chk("first_count", 32'(sample_count), 1);
    step();
    chk("first_drained", 32'(level), 0);

    // Fill with the consumer stalled: two drops past full
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      capture(25'(201 + k), (k < 4), 1'b0);
      chk("ramp_level", 32'(level), (k < 4) ? 32'(k + 1) : 32'd4);
    end
    chk("full_head", 32'(out_data), 201);
    chk("full_ovf", 32'(overflow), 1);
    chk("full_count", 32'(sample_count), 5);

    // Clear coinciding with a new drop keeps the flag; a lone clear drops it
    capture(25'd207, 1'b0, 1'b1);
    chk("ovf_coincide", 32'(overflow), 1);
    chk("ovf_coincide_level", 32'(level), 4);
    step();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);

    // Full FIFO with a pop on the capture edge: both succeed
    while (phase != 4) step();
    cic_out = 25'd208;
    out_ready = 1'b1;
    exp_q.push_back(25'd208);
    $display("capture value=208 keep=1 clr_ovf=0 (with pop)");
    step();
    out_ready = 1'b0;
    chk("fullpop_level", 32'(level), 4);
    chk("fullpop_ovf", 32'(overflow), 0);
    chk("fullpop_count", 32'(sample_count), 6);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && level != 0; i++) step();
    chk("drain_level", 32'(level), 0);

    // Disable mid-period: counter and divided clock freeze, settle restarts
    while (phase != 200) step();
    chk("pre_hold_dclk", 32'(divided_clk), 1);
    enable = 1'b0;
    repeat (500) step();
    chk("hold_dclk", 32'(divided_clk), 1);
    chk("hold_level", 32'(level), 0);
    enable = 1'b1;
    repeat (55) step();
    chk("resume_55_dclk", 32'(divided_clk), 1);
    step();
    chk("resume_wrap_dclk", 32'(divided_clk), 0);
    capture(25'd301, 1'b0, 1'b0);
    capture(25'd302, 1'b0, 1'b0);
    capture(25'd303, 1'b0, 1'b0);
    chk("resettle_level", 32'(level), 0);
    chk("resettle_count", 32'(sample_count), 6);
    capture(25'd304, 1'b1, 1'b0);
    chk("resettle_kept_count", 32'(sample_count), 7);
    step();
    chk("resettle_drained", 32'(level), 0);

    // Reset with three samples buffered
    out_ready = 1'b0;
    capture(25'd401, 1'b1, 1'b0);
    capture(25'd402, 1'b1, 1'b0);
    capture(25'd403, 1'b1, 1'b0);
    chk("pre_reset_level3", 32'(level), 3);
    reset_n = 1'b0;
    #2;
    chk("reset_before_edge", 32'(level), 3);
    step();
    exp_q.delete();
    chk("midrst_level", 32'(level), 0);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_dclk", 32'(divided_clk), 0);
    chk("midrst_count", 32'(sample_count), 0);
    chk("midrst_ovf", 32'(overflow), 0);
    chk("midrst_data", 32'(out_data), 0);

    reset_n = 1'b1; enable = 1'b1; out_ready = 1'b1;
    capture(25'd501, 1'b0, 1'b0);
    capture(25'd502, 1'b0, 1'b0);
    capture(25'd503, 1'b0, 1'b0);
    chk("post_rst_settle", 32'(level), 0);
    capture(25'd504, 1'b1, 1'b0);
    chk("post_rst_count", 32'(sample_count), 1);
    step();
    step();
    chk("post_rst_drained", 32'(level), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
